// File: rtl/mont_mul.sv
// Bit-serial radix-2 Montgomery multiplier: one loop iteration per clock.
// result = A*B*2^-WIDTH mod M, left unreduced in [0, 2M) for the downstream reduction stage.
module mont_mul #(
  parameter int WIDTH = 512
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic [WIDTH+1:0] result,
  output logic             busy,
  output logic             done
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOOP = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH:0]   c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH+1:0] res_q, res_d;

  logic [WIDTH+1:0] s_s;
  logic [WIDTH+1:0] t_s;
  logic [WIDTH+1:0] c_nx_s;

  // One Montgomery step at full WIDTH+2 precision; the shift keeps the top bit, so C < 2M stays exact.
  always_comb begin
    s_s    = {1'b0, c_q} + (a_q[0] ? {2'b00, b_q} : {(WIDTH+2){1'b0}});
    t_s    = s_s + (s_s[0] ? {2'b00, m_q} : {(WIDTH+2){1'b0}});
    c_nx_s = t_s >> 1;
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LOOP;
          a_d     = in_a;
          b_d     = in_b;
          m_d     = in_m;
          c_d     = {(WIDTH+1){1'b0}};
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOOP: begin
        c_d   = c_nx_s[WIDTH:0];
        a_d   = a_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          res_d   = c_nx_s;
        end else begin
          state_d = S_LOOP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      m_q     <= {WIDTH{1'b0}};
      c_q     <= {(WIDTH+1){1'b0}};
      cnt_q   <= {CW{1'b0}};
      res_q   <= {(WIDTH+2){1'b0}};
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  // Status decodes straight from the state register, so start has no path to busy/done.
  assign result = res_q;
  assign busy   = (state_q == S_LOOP);
  assign done   = (state_q == S_DONE);

endmodule

// File: tb/tb_mont_mul.sv
// Self-checking bench for mont_mul at WIDTH=8: directed vectors plus a cycle-level
// reference that predicts busy/done/result from the Montgomery identity, not the loop.
module tb_mont_mul;

  localparam int W  = 8;
  localparam int RW = W + 2;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic [W-1:0]  in_m = '0;
  logic [W+1:0]  result;
  logic          busy;
  logic          done;

  int total = 0;
  int bad   = 0;
  logic chk_on = 1'b0;

  mont_mul #(.WIDTH(W)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .in_a(in_a), .in_b(in_b), .in_m(in_m),
    .result(result), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Bit-serial radix-2 REDC yields (A*B + Q*M)/R with Q = -A*B*M^-1 mod R, R = 2^W.
  function automatic longint golden(input longint a, input longint b, input longint m);
    longint r, minv, q;
    r = 64'sd1 <<< W;
    minv = 0;
    for (longint x = 1; x < r; x += 2) begin
      if (((m * x) % r) == 1 && minv == 0) minv = x;
    end
    q = (r - (((a * b) % r) * minv) % r) % r;
    return (a * b + q * m) / r;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference timeline: an accepted start keeps the unit busy for W cycles, then done pulses once.
  int           rem;
  logic         m_done;
  logic [W+1:0] m_res, m_pend;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rem <= 0; m_done <= 1'b0; m_res <= '0; m_pend <= '0;
    end else begin
      m_done <= 1'b0;
      if (rem > 0) begin
        rem <= rem - 1;
        if (rem == 1) begin
          m_done <= 1'b1;
          m_res  <= m_pend;
        end
      end else if (start) begin
        rem    <= W;
        m_pend <= RW'(golden(longint'(in_a), longint'(in_b), longint'(in_m)));
      end
    end
  end

  always @(negedge clk) begin
    if (resetn && chk_on) begin
      check("model_busy", longint'(busy), (rem > 0) ? 1 : 0);
      check("model_done", longint'(done), longint'(m_done));
      check("model_result", longint'(result), longint'(m_res));
    end
  end

  task automatic run_op(input longint a, input longint b, input longint m,
                        output int lat, output int busy_n);
    @(negedge clk);
    in_a = W'(a); in_b = W'(b); in_m = W'(m); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    busy_n = busy ? 1 : 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy) busy_n++;
    end
  endtask

  int lat, bn, cnt;
  longint ra, rb, rm;

  initial begin
    #12;
    check("reset_result", longint'(result), 0);
    check("reset_busy", longint'(busy), 0);
    check("reset_done", longint'(done), 0);
    @(negedge clk);
    resetn = 1'b1;
    chk_on = 1'b1;

    check("gold_1_1", golden(1, 1, 239), 225);
    check("gold_238", golden(238, 238, 239), 225);
    check("gold_0_200", golden(0, 200, 239), 0);

    // Basic product, latency, busy width, single-cycle done and result hold.
    run_op(1, 1, 239, lat, bn);
    check("t1_result", longint'(result), 225);
    check("t1_latency", lat, W);
    check("t1_busy_cycles", bn, W);
    @(negedge clk);
    check("t1_done_width", longint'(done), 0);
    check("t1_hold", longint'(result), 225);

    run_op(0, 200, 239, lat, bn);
    check("t2_zero", longint'(result), 0);
    run_op(238, 238, 239, lat, bn);
    check("t2_max", longint'(result), 225);
    check("t2_lt_2m", (result < 10'd478) ? 1 : 0, 1);

    // Start during LOOP is ignored; start during DONE chains immediately.
    @(negedge clk);
    in_a = 8'd5; in_b = 8'd7; in_m = 8'd239; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    in_a = 8'd100; in_b = 8'd100; start = 1'b1;
    @(negedge clk); start = 1'b0;
    cnt = 0;
    while (!done && cnt < 40) begin @(negedge clk); cnt++; end
    check("t4_ignored", longint'(result), golden(5, 7, 239));
    in_a = 8'd17; in_b = 8'd33; start = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      cnt++;
    end while (!done && cnt < 40);
    check("t4_chain_period", cnt, W + 1);
    check("t4_chain_result", longint'(result), golden(17, 33, 239));

    // Asynchronous reset mid-loop clears everything at once.
    @(negedge clk);
    in_a = 8'd200; in_b = 8'd150; in_m = 8'd239; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("t5_busy", longint'(busy), 0);
    check("t5_done", longint'(done), 0);
    check("t5_result", longint'(result), 0);
    @(negedge clk);
    resetn = 1'b1;
    run_op(123, 45, 239, lat, bn);
    check("t5_after", longint'(result), golden(123, 45, 239));
    check("t5_latency", lat, W);

    run_op(254, 254, 255, lat, bn);
    check("edge_m255", longint'(result), golden(254, 254, 255));

    // Random odd moduli with operands below M.
    for (int i = 0; i < 12; i++) begin
      rm = longint'($urandom_range(127, 1)) * 2 + 1;
      ra = longint'($urandom_range(32'(rm - 1), 0));
      rb = longint'($urandom_range(32'(rm - 1), 0));
      run_op(ra, rb, rm, lat, bn);
      check("rand_result", longint'(result), golden(ra, rb, rm));
      check("rand_lt_2m", (longint'(result) < 2 * rm) ? 1 : 0, 1);
      check("rand_busy_cycles", bn, W);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
